// File: rtl/sseg_arbiter_if.sv
// Bus between the display requesters and the seven-segment arbiter.
// The requesters drive req/data. The arbiter returns the grant and the word for the scan driver.
interface sseg_arbiter_if;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  gnt;
    logic [1:0]  owner;
    logic [15:0] disp_data;
    logic        disp_valid;

    modport master (
        output req, data0, data1, data2,
        input  gnt, owner, disp_data, disp_valid
    );

    modport slave (
        input  req, data0, data1, data2,
        output gnt, owner, disp_data, disp_valid
    );
endinterface

// File: rtl/sseg_arbiter.sv
// Round-robin owner of the shared 4-digit seven-segment display.
// Each owner keeps the display for a minimum hold time, and a blank gap separates consecutive owners.
module sseg_arbiter #(
    parameter logic [23:0] HOLD_CYCLES  = 24'd5_000_000,
    parameter logic [15:0] BLANK_CYCLES = 16'd50_000
) (
    input  logic          clk,
    input  logic          reset_n,
    sseg_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;

    localparam logic [1:0]  NO_OWNER  = 2'd3;
    localparam logic [23:0] HOLD_MAX  = HOLD_CYCLES - 24'd1;
    localparam logic [15:0] BLANK_MAX = BLANK_CYCLES - 16'd1;

    state_t      state, state_n;
    logic [2:0]  gnt_q, gnt_n;
    logic [1:0]  owner_q, owner_n;
    logic [15:0] data_q, data_n;
    logic        valid_q, valid_n;
    logic [23:0] hold_cnt, hold_n;
    logic [15:0] blank_cnt, blank_n;
    logic [1:0]  last, last_n;

    logic [1:0]  c1, c2, c3, win;
    logic        do_grant;

    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [15:0] sel_data(input logic [1:0] i, input logic [15:0] d0,
                                             input logic [15:0] d1, input logic [15:0] d2);
        case (i)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return 16'h0000;
        endcase
    endfunction

    // The search starts one past the last winner, so the previous owner has the lowest priority.
    always_comb begin
        c1 = rr_next(last);
        c2 = rr_next(c1);
        c3 = rr_next(c2);
        if (bus.req[c1])      win = c1;
        else if (bus.req[c2]) win = c2;
        else if (bus.req[c3]) win = c3;
        else                  win = NO_OWNER;
    end

    // NOTE: every next-state variable gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        gnt_n    = 3'b000;
        owner_n  = NO_OWNER;
        data_n   = 16'h0000;
        valid_n  = 1'b0;
        hold_n   = 24'd0;
        blank_n  = 16'd0;
        last_n   = last;
        do_grant = 1'b0;

        case (state)
            IDLE: do_grant = |bus.req;

            OWN: begin
                if (!(|(bus.req & gnt_q)) ||
                    (hold_cnt == HOLD_MAX && |(bus.req & ~gnt_q))) begin
                    state_n = BLANK;
                end else begin
                    gnt_n   = gnt_q;
                    owner_n = owner_q;
                    valid_n = 1'b1;
                    data_n  = sel_data(owner_q, bus.data0, bus.data1, bus.data2);
                    hold_n  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 24'd1;
                end
            end

            BLANK: begin
                if (blank_cnt == BLANK_MAX) begin
                    do_grant = |bus.req;
                    state_n  = IDLE;
                end else begin
                    blank_n = blank_cnt + 16'd1;
                end
            end

            default: state_n = IDLE;
        endcase

        if (do_grant) begin
            state_n = OWN;
            gnt_n   = 3'b001 << win;
            owner_n = win;
            valid_n = 1'b1;
            data_n  = sel_data(win, bus.data0, bus.data1, bus.data2);
            last_n  = win;
        end
    end

    // NOTE: registers are updated only with non-blocking assignments, so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt_q     <= 3'b000;
            owner_q   <= NO_OWNER;
            data_q    <= 16'h0000;
            valid_q   <= 1'b0;
            hold_cnt  <= 24'd0;
            blank_cnt <= 16'd0;
            last      <= 2'd2;
        end else begin
            state     <= state_n;
            gnt_q     <= gnt_n;
            owner_q   <= owner_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            hold_cnt  <= hold_n;
            blank_cnt <= blank_n;
            last      <= last_n;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.owner      = owner_q;
    assign bus.disp_data  = data_q;
    assign bus.disp_valid = valid_q;

endmodule

// File: tb/tb_sseg_arbiter.sv
// Self-checking bench for sseg_arbiter. It runs directed scenarios and then random traffic.
// The random traffic is checked against an owner/age/gap reference model.
module tb_sseg_arbiter;

    localparam logic [23:0] HOLD  = 24'd4;
    localparam logic [15:0] BLANK = 16'd2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    int          m_owner, m_age, m_gap, m_last;
    logic [15:0] m_data;

    always #5 clk = ~clk;

    sseg_arbiter_if bus ();

    sseg_arbiter #(.HOLD_CYCLES(HOLD), .BLANK_CYCLES(BLANK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Reference model. It tracks who owns the display, for how many edges the owner has held it,
    // and how many gap edges remain.
    function automatic void model_edge();
        logic [15:0] d [3];
        logic [2:0]  mask;
        d[0] = bus.data0; d[1] = bus.data1; d[2] = bus.data2;
        if (!reset_n) begin
            m_owner = -1; m_age = 0; m_gap = 0; m_last = 2; m_data = 16'h0000;
            return;
        end
        if (m_owner >= 0) begin
            mask = 3'(1 << m_owner);
            if (!bus.req[m_owner] || (m_age >= int'(HOLD) - 1 && (bus.req & ~mask) != 3'b000)) begin
                m_owner = -1; m_gap = int'(BLANK); m_data = 16'h0000;
            end else begin
                m_age++; m_data = d[m_owner];
            end
        end else begin
            if (m_gap > 0) m_gap--;
            m_data = 16'h0000;
            if (m_gap == 0) begin
                for (int k = 1; k <= 3; k++) begin
                    if (bus.req[(m_last + k) % 3]) begin
                        m_owner = (m_last + k) % 3;
                        m_last = m_owner; m_age = 0; m_data = d[m_owner];
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.req = 3'b000;
        step();
        step();
        reset_n = 1'b1;
    endtask

    function automatic logic [21:0] observed();
        return {bus.gnt, bus.owner, bus.disp_valid, bus.disp_data};
    endfunction

    localparam logic [21:0] IDLE_OUT = {3'b000, 2'd3, 1'b0, 16'h0000};

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (observed() !== IDLE_OUT) begin
                n_errors++;
                $display("FAIL reset_idle[%0d]: got %h want %h", i, observed(), IDLE_OUT);
            end
        end
    endtask

    task automatic test_single_owner();
        logic [21:0] exp;
        bus.data0 = 16'h1234;
        bus.req = 3'b001;
        step();
        exp = {3'b001, 2'd0, 1'b1, 16'h1234};
        n_checks++;
        if (observed() !== exp) begin
            n_errors++; $display("FAIL single_grant: got %h want %h", observed(), exp);
        end
        bus.data0 = 16'hBEEF;
        exp = {3'b001, 2'd0, 1'b1, 16'hBEEF};
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (observed() !== exp) begin
                n_errors++; $display("FAIL single_hold[%0d]: got %h want %h", i, observed(), exp);
            end
        end
        bus.req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (observed() !== IDLE_OUT) begin
                n_errors++; $display("FAIL single_release[%0d]: got %h want %h", i, observed(), IDLE_OUT);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] words [3];
        int          order [4];
        logic [21:0] exp;
        words = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
        order = '{0, 1, 2, 0};
        apply_reset();
        bus.data0 = words[0]; bus.data1 = words[1]; bus.data2 = words[2];
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            exp = {3'(1 << order[i]), 2'(order[i]), 1'b1, words[order[i]]};
            for (int c = 0; c < 4; c++) begin
                step();
                n_checks++;
                if (observed() !== exp) begin
                    n_errors++; $display("FAIL rr_own[%0d.%0d]: got %h want %h", i, c, observed(), exp);
                end
            end
            if (i < 3) begin
                for (int b = 0; b < 2; b++) begin
                    step();
                    n_checks++;
                    if (observed() !== IDLE_OUT) begin
                        n_errors++; $display("FAIL rr_gap[%0d.%0d]: got %h want %h", i, b, observed(), IDLE_OUT);
                    end
                end
            end
        end
        bus.req = 3'b000;
    endtask

    task automatic test_early_release();
        logic [21:0] exp [5];
        apply_reset();
        bus.data1 = 16'h1111; bus.data2 = 16'h2222;
        exp = '{{3'b010, 2'd1, 1'b1, 16'h1111}, {3'b010, 2'd1, 1'b1, 16'h1111},
                IDLE_OUT, IDLE_OUT, {3'b100, 2'd2, 1'b1, 16'h2222}};
        for (int i = 0; i < 5; i++) begin
            bus.req = (i == 0) ? 3'b010 : (i == 1) ? 3'b110 : 3'b100;
            step();
            n_checks++;
            if (observed() !== exp[i]) begin
                n_errors++; $display("FAIL early_release[%0d]: got %h want %h", i, observed(), exp[i]);
            end
        end
        bus.req = 3'b000;
    endtask

    task automatic test_sole_rerequest();
        logic [2:0]  reqs [9];
        logic [21:0] exp [9];
        apply_reset();
        bus.data0 = 16'h0F0F; bus.data1 = 16'h5A5A;
        reqs = '{3'b010, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
        exp = '{{3'b010, 2'd1, 1'b1, 16'h5A5A}, IDLE_OUT, IDLE_OUT, {3'b010, 2'd1, 1'b1, 16'h5A5A},
                IDLE_OUT, IDLE_OUT, IDLE_OUT, IDLE_OUT, {3'b001, 2'd0, 1'b1, 16'h0F0F}};
        for (int i = 0; i < 9; i++) begin
            bus.req = reqs[i];
            step();
            n_checks++;
            if (observed() !== exp[i]) begin
                n_errors++; $display("FAIL sole_rerequest[%0d]: got %h want %h", i, observed(), exp[i]);
            end
        end
        bus.req = 3'b000;
    endtask

    task automatic test_reset_mid_own();
        logic [21:0] exp;
        apply_reset();
        bus.data0 = 16'hCAFE; bus.data2 = 16'hD00D;
        bus.req = 3'b100;
        step();
        step();
        exp = {3'b100, 2'd2, 1'b1, 16'hD00D};
        n_checks++;
        if (observed() !== exp) begin
            n_errors++; $display("FAIL midown_pre: got %h want %h", observed(), exp);
        end
        reset_n = 1'b0;
        step();
        n_checks++;
        if (observed() !== IDLE_OUT) begin
            n_errors++; $display("FAIL midown_reset: got %h want %h", observed(), IDLE_OUT);
        end
        reset_n = 1'b1;
        bus.req = 3'b111;
        step();
        exp = {3'b001, 2'd0, 1'b1, 16'hCAFE};
        n_checks++;
        if (observed() !== exp) begin
            n_errors++; $display("FAIL midown_regrant: got %h want %h", observed(), exp);
        end
        bus.req = 3'b000;
    endtask

    task automatic test_random();
        logic [21:0] exp;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
            bus.data0 = 16'($urandom);
            bus.data1 = 16'($urandom);
            bus.data2 = 16'($urandom);
            step();
            exp = {(m_owner >= 0) ? 3'(1 << m_owner) : 3'b000,
                   (m_owner >= 0) ? 2'(m_owner) : 2'd3,
                   m_owner >= 0, m_data};
            n_checks++;
            if (observed() !== exp) begin
                n_errors++; $display("FAIL random[%0d]: got %h want %h", i, observed(), exp);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 3'b000;
        bus.data0 = 16'h0000;
        bus.data1 = 16'h0000;
        bus.data2 = 16'h0000;
        m_owner = -1; m_age = 0; m_gap = 0; m_last = 2; m_data = 16'h0000;
        #2;
        test_reset();
        test_single_owner();
        test_round_robin();
        test_early_release();
        test_sole_rerequest();
        test_reset_mid_own();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sseg_arbiter.md
# sseg_arbiter

Time-shares the board's single 4-digit seven-segment display between three requesters (e.g. CPU address bus, data bus, debug monitor). Sits directly in front of the seven-segment scan driver and supplies its 16-bit `data` word. A round-robin state machine grants ownership, enforces a minimum hold time per owner and inserts a blank gap between owners so digits never show a mixed value.

## Interface
- `HOLD_CYCLES`, 24'd5_000_000: minimum cycles an owner keeps the display while others wait; legal range 1..2^24-1.
- `BLANK_CYCLES`, 16'd50_000: blank gap between owners; legal range 1..2^16-1.

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `req`  in  3  request per requester; level, held high while display wanted.
- `data0`  in  16  requester 0 display value.
- `data1`  in  16  requester 1 display value.
- `data2`  in  16  requester 2 display value.
- `gnt`  out  3  one-hot grant; all-zero when nobody owns.
- `owner`  out  2  index of current owner; 2'd3 when none.
- `disp_data`  out  16  word to the scan driver.
- `disp_valid`  out  1  high while `disp_data` belongs to an owner; low means blank.

## Operation
- All outputs registered. Reset (`reset_n`=0 at an edge): state IDLE, `gnt`=3'b000, `owner`=2'd3, `disp_data`=16'h0000, `disp_valid`=0, `hold_cnt`=0, `blank_cnt`=0, round-robin pointer `last`=2'd2 (so requester 0 wins first).
- Arbitration: search `last`+1, `last`+2, `last`+3 (mod 3); first with `req` set wins. Winner becomes `owner`, `last` <= winner.
- IDLE: outputs as reset values except `last` retained. If `req`!=0: arbitrate, go OWN; `gnt`, `owner`, `disp_valid`=1 and `disp_data`<=data of winner all take effect on the same edge; `hold_cnt`<=0.
- OWN: each edge `disp_data`<=data[owner]; `hold_cnt` increments, saturating at `HOLD_CYCLES`-1.
  - Owner drops `req`: go BLANK on that edge, regardless of `hold_cnt`.
  - `hold_cnt`==`HOLD_CYCLES`-1 and any other `req` set: go BLANK.
  - Otherwise stay; a lone owner keeps the display indefinitely.
- BLANK: `gnt`=0, `owner`=2'd3, `disp_valid`=0, `disp_data`=16'h0000, `blank_cnt` counts 0..`BLANK_CYCLES`-1. On the edge where `blank_cnt`==`BLANK_CYCLES`-1: if `req`!=0 arbitrate and enter OWN (as from IDLE), else IDLE. `req` changes during BLANK are ignored until that edge.
- The previous owner is eligible again but has lowest priority (pointer rotation). If it is the only requester, it is regranted after the gap.
- `req` bits outside the owner never preempt before hold expiry; there is no priority override.
- `data*` of non-owners is ignored. Counters never wrap: `hold_cnt` saturates, `blank_cnt` clears on leaving BLANK.

## Timing
- Request to grant latency from IDLE: `req` high before edge N, then `gnt`/`disp_valid`/`disp_data` valid after edge N (1 cycle).
- Data latency in OWN: 1 cycle (`data`x sampled at edge N appears after edge N).
- Release: owner `req` low before edge N, then `gnt`=0, `disp_valid`=0 after edge N. Next grant after edge N+`BLANK_CYCLES`.
- Hold expiry: owner granted at edge G, competitor waiting, then BLANK entered at edge G+`HOLD_CYCLES`.
- `gnt` is never non-zero in two consecutive owners without at least `BLANK_CYCLES` zero cycles between them.
- Reset asserted mid-OWN or mid-BLANK: all outputs return to reset values at that edge and `last` resets to 2.

## Test plan
- Reset/idle: `reset_n`=0 for 2 cycles, `req`=0, then `gnt`=000, `owner`=3, `disp_data`=0000, `disp_valid`=0 held for 10 cycles.
- Single owner (HOLD=4, BLANK=2): `req`=001, `data0`=16'h1234, then grant 1 cycle later. Change `data0` to 16'hBEEF; `disp_data` follows 1 cycle later. Owner is retained for 20 cycles with no other requests.
- Round-robin: `req`=111 from IDLE. Grant order is 0,1,2,0, each for 4 cycles, with exactly 2 blank cycles (`disp_valid`=0, `disp_data`=0) between owners.
- Early release: requester 1 owns, drops `req` at `hold_cnt`=1, then BLANK next edge. Requester 2 (pending) is granted 2 cycles later.
- Sole re-request: `req`=010, owner drops and reraises during BLANK, then requester 1 is regranted right after the gap. If `req` is still low at the gap end, go IDLE.
- Reset mid-OWN: while requester 2 owns, pulse `reset_n` low for 1 cycle, then reset values appear. With `req`=111 afterward, requester 0 is granted first.
